// File: rtl/ihadamard4x4_sink.sv
// ihadamard4x4_sink
//
// Inverse 4x4 Hadamard transform sink. It collects 16 signed coefficients
// Y[0][0]..Y[3][3] in row-major order over the din/wen write interface. It
// then computes X = (H*Y*H)/16, where H is the natural-order 4x4 Hadamard
// matrix. Each result is rounded half-up and clipped to the unsigned pixel
// range, and the 16 pixels stream out row-major on a valid/ready handshake.
//
// Processing sequence:
//   LOAD : 16 accepted writes
//   ROW  : 4 cycles, one row butterfly per cycle       (T = Y*H)
//   COL  : 4 cycles, one column butterfly per cycle    (S = H*T), round + clip
//   OUT  : 16 handshakes
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   din         signed coefficient (COEF_W bits)
//   wen         write strobe, accepted while din_ready=1
//   din_ready   high in LOAD
//   dout        reconstructed pixel (PIX_W bits)
//   dout_valid  dout holds a valid pixel
//   dout_ready  consumer accepts dout
//   dout_last   high with the 16th pixel
//   busy        high in ROW, COL and OUT
//   err_drop    registered one-cycle pulse for each write discarded outside LOAD
module ihadamard4x4_sink #(
    parameter int COEF_W = 13,
    parameter int PIX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [COEF_W-1:0] din,
    input  logic                     wen,
    output logic                     din_ready,
    output logic [PIX_W-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     busy,
    output logic                     err_drop
);

    localparam int T_W = COEF_W + 2;
    localparam int S_W = COEF_W + 4;
    localparam logic signed [S_W:0] PIX_MAX = (S_W+1)'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;

    state_t state, state_nxt;

    logic [3:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic [1:0] ph;

    logic signed [COEF_W-1:0] coef  [16];
    logic signed [T_W-1:0]    t_buf [16];
    logic [PIX_W-1:0]         pix   [16];

    logic signed [S_W-1:0] bf_in  [4];
    logic signed [S_W-1:0] bf_out [4];

    // Round half-up by 1/16, then clip to [0, 2^PIX_W-1].
    function automatic logic [PIX_W-1:0] round_clip(input logic signed [S_W-1:0] s);
        logic signed [S_W:0] p;
        p = (S_W+1)'(s) + (S_W+1)'(8);
        p = p >>> 4;
        if (p < 0)
            return '0;
        else if (p > PIX_MAX)
            return PIX_MAX[PIX_W-1:0];
        else
            return p[PIX_W-1:0];
    endfunction

    assign din_ready  = (state == LOAD);
    assign busy       = (state != LOAD);
    assign dout_valid = (state == OUT);
    assign dout       = dout_valid ? pix[rd_cnt] : '0;
    assign dout_last  = dout_valid && (rd_cnt == 4'd15);

    // Shared 4-point butterfly: a row of Y in ROW, a column of T in COL.
    // Operands are sign-extended to the widest (column) width. The row
    // results fit in T_W, so the later truncation is lossless.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bf_in[k] = '0;
            if (state == ROW)
                bf_in[k] = S_W'(coef[{ph, 2'(k)}]);
            else if (state == COL)
                bf_in[k] = S_W'(t_buf[{2'(k), ph}]);
        end
        bf_out[0] = bf_in[0] + bf_in[1] + bf_in[2] + bf_in[3];
        bf_out[1] = bf_in[0] - bf_in[1] + bf_in[2] - bf_in[3];
        bf_out[2] = bf_in[0] + bf_in[1] - bf_in[2] - bf_in[3];
        bf_out[3] = bf_in[0] - bf_in[1] - bf_in[2] + bf_in[3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (wen && wr_cnt == 4'd15)     state_nxt = ROW;
            ROW:  if (ph == 2'd3)                 state_nxt = COL;
            COL:  if (ph == 2'd3)                 state_nxt = OUT;
            OUT:  if (dout_ready && rd_cnt == 4'd15) state_nxt = LOAD;
            default:                              state_nxt = LOAD;
        endcase
    end

    // Counters wrap to zero at the end of each phase, so every return to
    // LOAD starts from a clean count without explicit clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            ph       <= '0;
            err_drop <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                coef[i]  <= '0;
                t_buf[i] <= '0;
                pix[i]   <= '0;
            end
        end else begin
            err_drop <= wen && (state != LOAD);
            case (state)
                LOAD: begin
                    if (wen) begin
                        coef[wr_cnt] <= din;
                        wr_cnt       <= wr_cnt + 4'd1;
                    end
                end
                ROW: begin
                    for (int k = 0; k < 4; k++)
                        t_buf[{ph, 2'(k)}] <= bf_out[k][T_W-1:0];
                    ph <= ph + 2'd1;
                end
                COL: begin
                    for (int k = 0; k < 4; k++)
                        pix[{2'(k), ph}] <= round_clip(bf_out[k]);
                    ph <= ph + 2'd1;
                end
                OUT: begin
                    if (dout_ready)
                        rd_cnt <= rd_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ihadamard4x4_sink.sv
module tb_ihadamard4x4_sink;

    localparam int COEF_W = 13;
    localparam int PIX_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [COEF_W-1:0] din;
    logic                     wen;
    logic                     din_ready;
    logic [PIX_W-1:0]         dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic                     dout_last;
    logic                     busy;
    logic                     err_drop;

    int n_chk  = 0;
    int n_pass = 0;

    logic signed [COEF_W-1:0] ycoef [16];
    int                       exp_pix [16];

    ihadamard4x4_sink #(.COEF_W(COEF_W), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wen        (wen),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dc(input int a, input int px);
        for (int i = 0; i < 16; i++) begin
            ycoef[i]   = '0;
            exp_pix[i] = px;
        end
        ycoef[0] = COEF_W'(a);
    endtask

    task automatic write_coefs();
        for (int i = 0; i < 16; i++) begin
            din = ycoef[i];
            wen = 1'b1;
            tick();
        end
        wen = 1'b0;
    endtask

    // Writes a block, optionally pulses two writes during ROW, then checks
    // that dout_valid rises exactly 8 edges after the 16th write.
    task automatic load_block(input bit drop_row);
        int cyc;
        write_coefs();
        wen = drop_row;
        din = 7;
        cyc = 0;
        while (!dout_valid && cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check_val("busy_row", busy, 1);
                check_val("din_ready_row", din_ready, 0);
            end
            if (drop_row && cyc <= 2) check_val("err_drop_row", err_drop, 1);
            if (drop_row && cyc == 3) check_val("err_drop_row_end", err_drop, 0);
            if (cyc == 2) wen = 1'b0;
        end
        wen = 1'b0;
        check_val("latency", cyc, 8);
    endtask

    task automatic read_block(input int stall_at, input bit drop_out);
        int         idx;
        int         cyc;
        bit         hs_now;
        bit         stalled;
        logic [7:0] hold;
        idx     = 0;
        cyc     = 0;
        stalled = 0;
        dout_ready = 1'b1;
        while (idx < 16 && cyc < 200) begin
            if (idx == stall_at && !stalled && dout_valid) begin
                dout_ready = 1'b0;
                hold = dout;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    cyc++;
                    check_val("stall_dout", dout, hold);
                    check_val("stall_valid", dout_valid, 1);
                end
                dout_ready = 1'b1;
                stalled = 1;
            end
            wen = drop_out && (idx == 2 || idx == 3 || idx == 15);
            din = 7;
            if (dout_valid) begin
                check_val($sformatf("pix%0d", idx), dout, exp_pix[idx]);
                check_val($sformatf("last%0d", idx), dout_last, (idx == 15) ? 1 : 0);
            end
            hs_now = dout_valid && dout_ready;
            tick();
            cyc++;
            if (wen) check_val($sformatf("err_drop_out%0d", idx), err_drop, 1);
            wen = 1'b0;
            if (hs_now) idx++;
        end
        check_val("handshakes", idx, 16);
        check_val("din_ready_after", din_ready, 1);
        check_val("valid_after", dout_valid, 0);
        tick();
        check_val("no_extra_valid", dout_valid, 0);
        check_val("err_drop_idle", err_drop, 0);
    endtask

    initial begin
        rst        = 1'b1;
        wen        = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        #12;
        check_val("rst_din_ready", din_ready, 1);
        check_val("rst_dout", dout, 0);
        check_val("rst_valid", dout_valid, 0);
        check_val("rst_last", dout_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err_drop", err_drop, 0);
        rst = 1'b0;
        tick();

        // DC block
        set_dc(1600, 100);
        load_block(0);
        read_block(-1, 0);

        // One horizontal AC term
        set_dc(1600, 0);
        ycoef[1] = 13'sd160;
        for (int i = 0; i < 16; i++) exp_pix[i] = (i % 2 == 0) ? 110 : 90;
        load_block(0);
        read_block(-1, 0);

        // Clipping and rounding
        set_dc(4095, 255);
        load_block(0);
        read_block(-1, 0);
        set_dc(-1600, 0);
        load_block(0);
        read_block(-1, 0);
        set_dc(24, 2);
        load_block(0);
        read_block(-1, 0);
        set_dc(23, 1);
        load_block(0);
        read_block(-1, 0);

        // Dropped writes in ROW, OUT and the final handshake cycle
        set_dc(1600, 100);
        load_block(1);
        read_block(-1, 1);

        // Backpressure at pixel 5
        set_dc(1600, 0);
        ycoef[1] = 13'sd160;
        for (int i = 0; i < 16; i++) exp_pix[i] = (i % 2 == 0) ? 110 : 90;
        load_block(0);
        read_block(5, 0);

        // Reset during COL aborts the block
        set_dc(1600, 100);
        write_coefs();
        for (int i = 0; i < 5; i++) tick();
        check_val("col_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_val("abort_din_ready", din_ready, 1);
        check_val("abort_busy", busy, 0);
        check_val("abort_valid", dout_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dout_valid) check_val("abort_no_output", dout_valid, 0);
        end
        check_val("abort_idle_valid", dout_valid, 0);
        set_dc(800, 50);
        load_block(0);
        read_block(-1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
